// File: rtl/fuzz_stim_pkg.sv
// Shared types, constants and the xorshift32 step for the fuzz stimulus engine.
package fuzz_stim_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_e;
    typedef enum logic [1:0] {MODE_RAND, MODE_WALK, MODE_CNT, MODE_RSVD} mode_e;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] LANE_SALT = 32'h9E3779B9;

    // One xorshift32 step (13/17/5).
    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/fuzz_misr32.sv
// 32-bit MISR: folds an OUT_W-wide response into 32 bits (XOR of 32-bit chunks,
// top chunk zero-padded) and shifts it into a CRC-32-polynomial register.
module fuzz_misr32
    import fuzz_stim_pkg::*;
#(
    parameter int OUT_W = 159
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] data,
    output logic [31:0]      sig
);
    localparam int NCH = (OUT_W + 31) / 32;

    logic [NCH*32-1:0] padded;
    logic [31:0]       fold;
    logic [31:0]       sig_d, sig_q;

    // Zero-pad the response and XOR its 32-bit chunks together.
    always_comb begin
        padded = '0;
        padded[OUT_W-1:0] = data;
        fold = '0;
        for (int i = 0; i < NCH; i++) fold = fold ^ padded[i*32 +: 32];
    end

    // Clear has priority over the shift/compress step.
    always_comb begin
        sig_d = sig_q;
        if (clr)
            sig_d = '0;
        else if (en)
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/fuzz_stim_engine.sv
// Stimulus-and-capture engine: drives in_flat for num_cycles RUN cycles and
// compresses out_flat into a MISR signature. Optional cycle trace output is
// enabled by defining FUZZ_STIM_TRACE_EN (simulation only).
module fuzz_stim_engine
    import fuzz_stim_pkg::*;
#(
    parameter int IN_W  = 155,
    parameter int OUT_W = 159,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CYC_W-1:0] num_cycles,
    input  logic [1:0]       mode,
    output logic [IN_W-1:0]  in_flat,
    input  logic [OUT_W-1:0] out_flat,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cyc_count,
    output logic [31:0]      signature
);
    localparam int LANES = (IN_W + 31) / 32;
    localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_e                  state_d, state_q;
    mode_e                   mode_d, mode_q;
    logic [CYC_W-1:0]        num_d, num_q;
    logic [CYC_W-1:0]        cyc_d, cyc_q;
    logic [IN_W-1:0]         in_d, in_q;
    logic [IDX_W-1:0]        widx_d, widx_q;
    logic [LANES-1:0][31:0]  lanes_d, lanes_q;
    logic [LANES-1:0][31:0]  lanes_adv, lanes_seed;
    logic [LANES*32-1:0]     adv_flat;
    logic                    misr_clr, misr_en, load;

    // Per-lane next PRNG value and salted seed (a zero seed would lock xorshift at 0).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lanes_adv[i]  = xorshift32(lanes_q[i]);
            lanes_seed[i] = seed ^ (32'(i) * LANE_SALT);
            if (lanes_seed[i] == 32'h0) lanes_seed[i] = 32'h1;
        end
        adv_flat = lanes_adv;
    end

    // Next-state, run bookkeeping and stimulus vector selection.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        num_d    = num_q;
        cyc_d    = cyc_q;
        in_d     = in_q;
        widx_d   = widx_q;
        lanes_d  = lanes_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                mode_d   = mode_e'(mode);
                num_d    = num_cycles;
                cyc_d    = '0;
                widx_d   = '0;
                lanes_d  = lanes_seed;
                misr_clr = 1'b1;
                state_d  = SETTLE;
            end
            SETTLE: begin
                load    = (num_q != '0);
                state_d = (num_q != '0) ? RUN : DONE;
            end
            RUN: begin
                misr_en = 1'b1;
                cyc_d   = cyc_q + CYC_W'(1);
                if (cyc_d == num_q) state_d = DONE;
                else                load    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // The vector index equals cyc_d: 0 in SETTLE, the new count in RUN.
        if (load) begin
            lanes_d = lanes_adv;
            widx_d  = (widx_q == IDX_W'(IN_W - 1)) ? '0 : widx_q + IDX_W'(1);
            case (mode_q)
                MODE_WALK: in_d = IN_W'(1'b1) << widx_q;
                MODE_CNT:  in_d = IN_W'(cyc_d);
                default:   in_d = adv_flat[IN_W-1:0];
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Run configuration, counters, PRNG lanes and the stimulus register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_RAND;
            num_q   <= '0;
            cyc_q   <= '0;
            in_q    <= '0;
            widx_q  <= '0;
            lanes_q <= '0;
        end else begin
            mode_q  <= mode_d;
            num_q   <= num_d;
            cyc_q   <= cyc_d;
            in_q    <= in_d;
            widx_q  <= widx_d;
            lanes_q <= lanes_d;
        end
    end

    fuzz_misr32 #(.OUT_W(OUT_W)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .data  (out_flat),
        .sig   (signature)
    );

    assign in_flat   = in_q;
    assign cyc_count = cyc_q;
    assign busy      = (state_q == SETTLE) || (state_q == RUN);
    assign done      = (state_q == DONE);

`ifdef FUZZ_STIM_TRACE_EN
    // Per-cycle trace of stimulus/response and a completion line.
    always @(posedge clk) begin
        if (rst_n && state_q == RUN)
            $write("CYCLE=%0d IN=%b OUT=%b\n", cyc_q, in_q, out_flat);
        if (rst_n && state_q == DONE)
            $write("FUZZ_DONE cycles=%0d sig=%h\n", cyc_q, signature);
    end
`endif

endmodule

// File: tb/tb_fuzz_stim_engine.sv
// Directed bench: a default-size engine (IN_W=155, OUT_W=159) and a small one
// (IN_W=8, OUT_W=32) share the control inputs.
module tb_fuzz_stim_engine;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [31:0]  seed, num;
    logic [1:0]   mode;
    logic [158:0] out_big;
    logic [31:0]  out_small;

    logic [154:0] in_big;
    logic         busy_b, done_b;
    logic [31:0]  cyc_b, sig_b;
    logic [7:0]   in_s;
    logic         busy_s, done_s;
    logic [31:0]  cyc_s, sig_s;

    int compared = 0, mismatched = 0;
    int nb, nd;
    logic [7:0] e;

    fuzz_stim_engine u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_cycles(num),
        .mode(mode), .in_flat(in_big), .out_flat(out_big), .busy(busy_b),
        .done(done_b), .cyc_count(cyc_b), .signature(sig_b)
    );

    fuzz_stim_engine #(.IN_W(8), .OUT_W(32), .CYC_W(32)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_cycles(num),
        .mode(mode), .in_flat(in_s), .out_flat(out_small), .busy(busy_s),
        .done(done_s), .cyc_count(cyc_s), .signature(sig_s)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Expected 155-bit random vector after 'steps' xorshift steps from seeding.
    function automatic logic [159:0] rand_vec(input logic [31:0] sd, input int steps);
        logic [159:0] v;
        logic [31:0]  x;
        for (int i = 0; i < 5; i++) begin
            x = sd ^ (32'(i) * 32'h9E3779B9);
            if (x == 32'h0) x = 32'h1;
            for (int s = 0; s < steps; s++) x = xs32(x);
            v[i*32 +: 32] = x;
        end
        v[159:155] = '0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a run request; returns with the engines in SETTLE.
    task automatic launch(input logic [31:0] sd, input logic [31:0] n, input logic [1:0] m);
        seed = sd; num = n; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; seed = '0; num = '0; mode = '0;
        out_big = '0; out_small = '0;
        tick(); tick();
        chk("rst_in_big", in_big, 0);
        chk("rst_in_s", in_s, 0);
        chk("rst_sig", sig_b, 0);
        chk("rst_busy", busy_b, 0);
        chk("rst_done", done_b, 0);
        chk("rst_cyc", cyc_b, 0);
        rst_n = 1'b1;
        tick();

        // Random mode, seed 1, one cycle
        launch(32'd1, 32'd1, 2'd0);
        chk("t1_busy_settle", busy_b, 1);
        tick();
        chk("t1_lane0", in_big[31:0], 32'h00042021);
        chk("t1_vec0", in_big, rand_vec(32'd1, 1));
        chk("t1_small", in_s, 8'h21);
        tick();
        chk("t1_done", done_b, 1);
        chk("t1_busy_done", busy_b, 0);
        chk("t1_cyc", cyc_b, 1);
        chk("t1_hold", in_big, rand_vec(32'd1, 1));
        tick();
        chk("t1_done_low", done_b, 0);

        // Walking one, 10 cycles; mid-run input changes must be ignored
        out_small = 32'h8000_0001;
        launch(32'h1234, 32'd10, 2'd1);
        mode = 2'd0; seed = 32'hFFFF; num = 32'd3;
        nb = 0; nd = 0;
        for (int n = 0; n < 14; n++) begin
            if (busy_s) nb++;
            if (done_s) nd++;
            if (n >= 1 && n <= 10) begin
                e = 8'h1 << ((n - 1) % 8);
                chk($sformatf("t2_walk%0d", n - 1), in_s, e);
            end
            tick();
        end
        chk("t2_cyc", cyc_s, 10);
        chk("t2_busy_cycles", nb, 11);
        chk("t2_done_pulses", nd, 1);
        chk("t2_big_walk", in_big, 160'h200);
        chk("t2_hold_s", in_s, 8'h02);

        // num_cycles = 0
        launch(32'd5, 32'd0, 2'd2);
        chk("t3_busy", busy_s, 1);
        chk("t3_nodone", done_s, 0);
        tick();
        chk("t3_done", done_s, 1);
        chk("t3_busy_low", busy_s, 0);
        chk("t3_sig", sig_s, 0);
        chk("t3_cyc", cyc_s, 0);
        chk("t3_in_s", in_s, 8'h02);
        chk("t3_in_big", in_big, 160'h200);
        tick();
        chk("t3_done_low", done_s, 0);

        // MISR, two cycles; big response has chunk0=1, top chunk=2 -> fold 3
        out_small = 32'h1;
        out_big = (159'h2 << 128) | 159'h1;
        launch(32'd5, 32'd2, 2'd2);
        tick();
        chk("t4_cnt0", in_s, 8'h00);
        tick();
        chk("t4_sig_s1", sig_s, 32'h1);
        chk("t4_sig_b1", sig_b, 32'h3);
        chk("t4_cnt1", in_s, 8'h01);
        tick();
        chk("t4_sig_s2", sig_s, 32'h3);
        chk("t4_sig_b2", sig_b, 32'h5);
        chk("t4_done", done_s, 1);
        chk("t4_hold", in_s, 8'h01);
        tick();

        // Counter mode, 5 cycles, start pulsed mid-run
        launch(32'd5, 32'd5, 2'd2);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int n = 0; n < 12; n++) begin
            if (done_s) nd++;
            tick();
        end
        chk("t5_cyc", cyc_s, 5);
        chk("t5_done_pulses", nd, 1);
        chk("t5_last_vec", in_s, 8'h04);
        chk("t5_idle", busy_s, 0);

        // Reset at cyc_count == 3
        launch(32'd5, 32'd5, 2'd2);
        tick(); tick(); tick(); tick();
        chk("t6_cyc3", cyc_s, 3);
        chk("t6_busy", busy_s, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_in_s", in_s, 0);
        chk("t6_in_big", in_big, 0);
        chk("t6_sig", sig_s, 0);
        chk("t6_busy0", busy_s, 0);
        chk("t6_done0", done_s, 0);
        chk("t6_cyc0", cyc_s, 0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 4; n++) begin
            if (done_s || busy_s) nd++;
            tick();
        end
        chk("t6_no_done", nd, 0);

        // Seed 0 behaves as seed 1 on lane 0; repeated run gives the same result
        out_small = 32'h1;
        for (int r = 0; r < 2; r++) begin
            launch(32'd0, 32'd3, 2'd0);
            tick();
            chk($sformatf("t7_lane0_r%0d", r), in_big[31:0], 32'h00042021);
            chk($sformatf("t7_vec0_r%0d", r), in_big, rand_vec(32'd0, 1));
            tick();
            chk($sformatf("t7_vec1_r%0d", r), in_big, rand_vec(32'd0, 2));
            tick();
            chk($sformatf("t7_vec2_r%0d", r), in_big, rand_vec(32'd0, 3));
            tick();
            chk($sformatf("t7_sig_r%0d", r), sig_s, 32'h7);
            chk($sformatf("t7_done_r%0d", r), done_s, 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
